hit_detector: RTL and testbench

Closes the loop around `game_controller`. It takes the ball position and direction from `game_controller`, plus the per-frame paddle (hand) centroid from the camera tracker. From these it generates `game_start`, a one-cycle `collision_detected` pulse, and `estimated_speed`, which is the paddle's recent motion magnitude. It sits between the video-processing centroid stage and `game_controller` in the 25 MHz pixel domain.

---
 rtl/game_pkg.sv | 22 ++
 rtl/hit_detector_if.sv | 28 ++
 rtl/speed_estimator.sv | 57 +++++
 rtl/hit_detector.sv | 147 ++++++++++++++
 tb/tb_hit_detector.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the game loop around game_controller.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COOLDOWN
    } hit_state_t;

    localparam int unsigned SCREEN_W    = 640;
    localparam int unsigned BALL_SIZE   = 20;
    localparam int unsigned BALL_EXIT_X = SCREEN_W - BALL_SIZE;
    localparam int unsigned COORD_W     = 10;
    localparam int unsigned EDGE_W      = 11;
    localparam int unsigned SPEED_W     = 10;

    // Negative box edges pin to the left/top screen border.
    function automatic logic [EDGE_W-1:0] clamp_edge(input logic signed [EDGE_W-1:0] v);
        return v[EDGE_W-1] ? '0 : $unsigned(v);
    endfunction

endpackage

// File: rtl/hit_detector_if.sv
// Tracker / game_controller side signals of hit_detector.
interface hit_detector_if;

    logic       upscale;
    logic       frame_tick;
    logic       paddle_valid;
    logic [8:0] paddle_x;
    logic [7:0] paddle_y;
    logic [9:0] ball_x_in;
    logic [9:0] ball_y_in;
    logic       is_ball_moving_left;
    logic       collision_detected;
    logic [9:0] estimated_speed;
    logic       game_start;

    modport master (
        output upscale, frame_tick, paddle_valid, paddle_x, paddle_y,
               ball_x_in, ball_y_in, is_ball_moving_left,
        input  collision_detected, estimated_speed, game_start
    );

    modport slave (
        input  upscale, frame_tick, paddle_valid, paddle_x, paddle_y,
               ball_x_in, ball_y_in, is_ball_moving_left,
        output collision_detected, estimated_speed, game_start
    );

endinterface

// File: rtl/speed_estimator.sv
// Paddle motion magnitude: Manhattan step per sample, averaged over the last four.
module speed_estimator (
    input  logic       clk_25MHZ,
    input  logic       reset_n,
    input  logic       sample_valid,
    input  logic [9:0] x,
    input  logic [8:0] y,
    output logic [9:0] speed
);
    import game_pkg::*;

    localparam int unsigned SUM_W = EDGE_W + 2;

    logic [9:0]              prev_x;
    logic [8:0]              prev_y;
    logic                    prev_valid;
    logic [3:0][EDGE_W-1:0]  hist;
    logic                    push_q;

    logic [9:0]        dx_c;
    logic [8:0]        dy_c;
    logic [EDGE_W-1:0] d_c;
    logic [SUM_W-1:0]  sum_c;
    logic [EDGE_W-1:0] avg_c;

    always_comb begin
        dx_c  = (x >= prev_x) ? (x - prev_x) : (prev_x - x);
        dy_c  = (y >= prev_y) ? (y - prev_y) : (prev_y - y);
        d_c   = prev_valid ? (EDGE_W'(dx_c) + EDGE_W'(dy_c)) : '0;
        sum_c = SUM_W'(hist[0]) + SUM_W'(hist[1]) + SUM_W'(hist[2]) + SUM_W'(hist[3]);
        avg_c = EDGE_W'(sum_c >> 2);
    end

    // Cycle 1: step into history; cycle 2: saturated average.
    always_ff @(posedge clk_25MHZ or negedge reset_n) begin
        if (!reset_n) begin
            prev_x     <= '0;
            prev_y     <= '0;
            prev_valid <= 1'b0;
            hist       <= '0;
            push_q     <= 1'b0;
            speed      <= '0;
        end else begin
            push_q <= sample_valid;
            if (sample_valid) begin
                prev_x     <= x;
                prev_y     <= y;
                prev_valid <= 1'b1;
                hist       <= {hist[2:0], d_c};
            end
            if (push_q) begin
                speed <= (avg_c > EDGE_W'(1023)) ? SPEED_W'(1023) : avg_c[9:0];
            end
        end
    end

endmodule

// File: rtl/hit_detector.sv
// Start / hit / speed generation between the centroid tracker and game_controller.
module hit_detector #(
    parameter int unsigned BALL_SIZE       = game_pkg::BALL_SIZE,
    parameter int unsigned PADDLE_W        = 16,
    parameter int unsigned PADDLE_H        = 64,
    parameter int unsigned START_FRAMES    = 30,
    parameter int unsigned COOLDOWN_FRAMES = 8
) (
    input  logic           clk_25MHZ,
    input  logic           reset_n,
    hit_detector_if.slave  bus
);
    import game_pkg::*;

    localparam int unsigned HALF_W  = PADDLE_W / 2;
    localparam int unsigned HALF_H  = PADDLE_H / 2;
    localparam int unsigned START_W = $clog2(START_FRAMES + 1);
    localparam int unsigned COOL_W  = $clog2(COOLDOWN_FRAMES + 1);

    hit_state_t         state;
    logic [START_W-1:0] start_cnt;
    logic [COOL_W-1:0]  cool_cnt;
    logic               frame_seen;
    logic               game_start_q;
    logic               collision_q;
    logic [SPEED_W-1:0] speed_w;

    logic [9:0] px_q;
    logic [8:0] py_q;
    logic [9:0] map_x_c;
    logic [8:0] map_y_c;

    logic signed [EDGE_W-1:0] left_s_c, top_s_c;
    logic [EDGE_W-1:0] box_l_c, box_r_c, box_t_c, box_b_c;
    logic [EDGE_W-1:0] bx0_c, bx1_c, by0_c, by1_c;
    logic overlap_c, exit_c, frame_good_c;

    // Camera coords to display coords.
    always_comb begin
        map_x_c = {bus.paddle_x, 1'b0};
        map_y_c = bus.upscale ? {bus.paddle_y, 1'b0} : {1'b0, bus.paddle_y};
    end

    always_ff @(posedge clk_25MHZ or negedge reset_n) begin
        if (!reset_n) begin
            px_q <= '0;
            py_q <= '0;
        end else if (bus.paddle_valid) begin
            px_q <= map_x_c;
            py_q <= map_y_c;
        end
    end

    // Half-open boxes: overlap needs each start strictly below the other's end.
    always_comb begin
        left_s_c  = $signed({1'b0, px_q}) - $signed(EDGE_W'(HALF_W));
        top_s_c   = $signed({2'b00, py_q}) - $signed(EDGE_W'(HALF_H));
        box_l_c   = clamp_edge(left_s_c);
        box_t_c   = clamp_edge(top_s_c);
        box_r_c   = EDGE_W'(px_q) + EDGE_W'(HALF_W);
        box_b_c   = EDGE_W'(py_q) + EDGE_W'(HALF_H);
        bx0_c     = EDGE_W'(bus.ball_x_in);
        by0_c     = EDGE_W'(bus.ball_y_in);
        bx1_c     = bx0_c + EDGE_W'(BALL_SIZE);
        by1_c     = by0_c + EDGE_W'(BALL_SIZE);
        overlap_c = (bx0_c < box_r_c) && (bx1_c > box_l_c) &&
                    (by0_c < box_b_c) && (by1_c > box_t_c);
        exit_c    = !bus.is_ball_moving_left && (bus.ball_x_in >= COORD_W'(BALL_EXIT_X));
        frame_good_c = frame_seen || bus.paddle_valid;
    end

    // A paddle sample on the tick cycle belongs to the frame that is ending.
    always_ff @(posedge clk_25MHZ or negedge reset_n) begin
        if (!reset_n) begin
            frame_seen <= 1'b0;
        end else if (bus.frame_tick) begin
            frame_seen <= 1'b0;
        end else if (bus.paddle_valid) begin
            frame_seen <= 1'b1;
        end
    end

    always_ff @(posedge clk_25MHZ or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            start_cnt    <= '0;
            cool_cnt     <= '0;
            game_start_q <= 1'b0;
            collision_q  <= 1'b0;
        end else begin
            game_start_q <= 1'b0;
            collision_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.frame_tick) begin
                        if (!frame_good_c) begin
                            start_cnt <= '0;
                        end else if (start_cnt == START_W'(START_FRAMES - 1)) begin
                            start_cnt    <= '0;
                            game_start_q <= 1'b1;
                            state        <= ARMED;
                        end else begin
                            start_cnt <= start_cnt + START_W'(1);
                        end
                    end
                end
                ARMED: begin
                    if (bus.is_ball_moving_left && overlap_c) begin
                        collision_q <= 1'b1;
                        cool_cnt    <= COOL_W'(COOLDOWN_FRAMES);
                        state       <= COOLDOWN;
                    end else if (exit_c) begin
                        state <= IDLE;
                    end
                end
                COOLDOWN: begin
                    if (exit_c) begin
                        cool_cnt <= '0;
                        state    <= IDLE;
                    end else if (bus.frame_tick) begin
                        if (cool_cnt <= COOL_W'(1)) begin
                            cool_cnt <= '0;
                            state    <= ARMED;
                        end else begin
                            cool_cnt <= cool_cnt - COOL_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    speed_estimator u_speed (
        .clk_25MHZ    (clk_25MHZ),
        .reset_n      (reset_n),
        .sample_valid (bus.paddle_valid),
        .x            (map_x_c),
        .y            (map_y_c),
        .speed        (speed_w)
    );

    assign bus.game_start         = game_start_q;
    assign bus.collision_detected = collision_q;
    assign bus.estimated_speed    = speed_w;

endmodule

// File: tb/tb_hit_detector.sv
// Scoreboard bench for hit_detector: start qualification, speed averaging, hit gating, reset.
module tb_hit_detector;

    localparam int EV_NONE  = 0;
    localparam int EV_START = 1;
    localparam int EV_HIT   = 2;

    logic clk_25MHZ = 1'b0;
    logic reset_n;
    always #20 clk_25MHZ = ~clk_25MHZ;

    hit_detector_if bus();

    hit_detector #(
        .BALL_SIZE       (20),
        .PADDLE_W        (16),
        .PADDLE_H        (64),
        .START_FRAMES    (30),
        .COOLDOWN_FRAMES (8)
    ) dut (
        .clk_25MHZ (clk_25MHZ),
        .reset_n   (reset_n),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int spd_q[$];

    int m_prev_x, m_prev_y, m_speed;
    bit m_prev_valid;
    int m_hist[4];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_25MHZ);
        #1;
    endtask

    task automatic model_reset();
        m_prev_x = 0; m_prev_y = 0; m_prev_valid = 0; m_speed = 0;
        for (int i = 0; i < 4; i++) m_hist[i] = 0;
        spd_q.delete();
    endtask

    task automatic see_pulse(input int ev);
        if (exp_q.size() == 0) check("unexpected_pulse", ev, EV_NONE);
        else check("pulse_kind", ev, exp_q.pop_front());
    endtask

    always @(negedge clk_25MHZ) begin
        if (reset_n) begin
            if (bus.game_start)         see_pulse(EV_START);
            if (bus.collision_detected) see_pulse(EV_HIT);
        end
    end

    task automatic drive_paddle(input int x, input int y);
        int mx, my, d, sum, hold;
        hold = m_speed;
        mx = x * 2;
        my = bus.upscale ? y * 2 : y;
        if (m_prev_valid)
            d = (mx > m_prev_x ? mx - m_prev_x : m_prev_x - mx) +
                (my > m_prev_y ? my - m_prev_y : m_prev_y - my);
        else
            d = 0;
        m_prev_x = mx; m_prev_y = my; m_prev_valid = 1;
        m_hist[0] = m_hist[1]; m_hist[1] = m_hist[2]; m_hist[2] = m_hist[3]; m_hist[3] = d;
        sum = m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3];
        m_speed = (sum / 4 > 1023) ? 1023 : sum / 4;
        spd_q.push_back(m_speed);
        bus.paddle_valid = 1'b1;
        bus.paddle_x     = 9'(x);
        bus.paddle_y     = 8'(y);
        step();
        bus.paddle_valid = 1'b0;
        check("speed_hold", int'(bus.estimated_speed), hold);
        step();
        check("speed_update", int'(bus.estimated_speed), spd_q.pop_front());
    endtask

    task automatic do_frame(input bit good, input int x, input int y);
        if (good) drive_paddle(x, y);
        step();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    task automatic run_frames(input int n, input bit good, input int x, input int y);
        for (int i = 0; i < n; i++) do_frame(good, x, y);
    endtask

    task automatic set_ball(input int x, input int y, input bit left);
        bus.ball_x_in           = 10'(x);
        bus.ball_y_in           = 10'(y);
        bus.is_ball_moving_left = left;
    endtask

    task automatic wait_hit(input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < 6 && seen == 0; i++) begin
            @(negedge clk_25MHZ);
            if (bus.collision_detected) seen = 1;
        end
        check(tag, seen, 1);
    endtask

    task automatic start_and_check(input string tag, input int x, input int y);
        run_frames(29, 1'b1, x, y);
        exp_q.push_back(EV_START);
        do_frame(1'b1, x, y);
        check(tag, int'(bus.game_start), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        bus.upscale = 1'b1; bus.frame_tick = 1'b0; bus.paddle_valid = 1'b0;
        bus.paddle_x = '0; bus.paddle_y = '0;
        set_ball(300, 400, 1'b0);
        model_reset();
        step(); step();
        check("reset_collision", int'(bus.collision_detected), 0);
        check("reset_start", int'(bus.game_start), 0);
        check("reset_speed", int'(bus.estimated_speed), 0);
        reset_n = 1'b1;
        step();

        // Missing frame 20 restarts the count.
        run_frames(19, 1'b1, 150, 5);
        do_frame(1'b0, 0, 0);
        start_and_check("start_pulse", 150, 5);
        step();
        check("start_width", int'(bus.game_start), 0);

        // Speed averaging.
        drive_paddle(100, 50);
        drive_paddle(104, 50);
        drive_paddle(104, 56);
        drive_paddle(110, 56);
        drive_paddle(110, 56);
        check("speed_final", int'(bus.estimated_speed), 8);

        // Hit, then cooldown suppression for 8 frames.
        drive_paddle(20, 100);
        set_ball(40, 180, 1'b1);
        exp_q.push_back(EV_HIT);
        step();
        check("hit_latency", int'(bus.collision_detected), 1);
        step();
        check("hit_width", int'(bus.collision_detected), 0);
        run_frames(7, 1'b0, 0, 0);
        check("cooldown_quiet", int'(bus.collision_detected), 0);
        exp_q.push_back(EV_HIT);
        do_frame(1'b0, 0, 0);
        wait_hit("rehit_after_cooldown");

        // Asynchronous reset while the pulse is high in COOLDOWN.
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_collision", int'(bus.collision_detected), 0);
        check("async_reset_start", int'(bus.game_start), 0);
        check("async_reset_speed", int'(bus.estimated_speed), 0);
        model_reset();
        set_ball(300, 400, 1'b0);
        step(); step();
        reset_n = 1'b1;
        step();
        start_and_check("restart_pulse", 20, 100);

        // Moving right over the paddle: no hit. Then exit right returns to IDLE.
        set_ball(40, 180, 1'b0);
        repeat (4) step();
        check("gated_no_hit", int'(bus.collision_detected), 0);
        set_ball(620, 180, 1'b0);
        step(); step();
        set_ball(40, 180, 1'b1);
        repeat (4) step();
        check("idle_no_hit", int'(bus.collision_detected), 0);
        run_frames(29, 1'b1, 20, 100);
        exp_q.push_back(EV_START);
        exp_q.push_back(EV_HIT);
        do_frame(1'b1, 20, 100);
        check("rearm_start", int'(bus.game_start), 1);
        step();
        check("hit_after_rearm", int'(bus.collision_detected), 1);

        // Non-upscaled paddle y.
        set_ball(300, 400, 1'b0);
        run_frames(8, 1'b0, 0, 0);
        bus.upscale = 1'b0;
        drive_paddle(20, 100);
        set_ball(40, 200, 1'b1);
        repeat (4) step();
        check("upscale_far_no_hit", int'(bus.collision_detected), 0);
        set_ball(40, 100, 1'b1);
        exp_q.push_back(EV_HIT);
        step();
        check("upscale_hit", int'(bus.collision_detected), 1);

        // Exit during COOLDOWN wins over re-arming.
        set_ball(620, 100, 1'b0);
        step();
        set_ball(40, 100, 1'b1);
        run_frames(10, 1'b0, 0, 0);
        check("exit_in_cooldown", int'(bus.collision_detected), 0);

        // Large jumps saturate the average.
        bus.upscale = 1'b1;
        drive_paddle(319, 239);
        drive_paddle(0, 0);
        drive_paddle(319, 239);
        drive_paddle(0, 0);
        drive_paddle(319, 239);
        check("speed_saturated", int'(bus.estimated_speed), 1023);

        step();
        check("pending_events", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
